deint_ddr_arbiter: RTL and testbench
====================================

Name: deint_ddr_arbiter

Overview:
Shares the DDR3 MIG user (app_*) interface between the deinterleaver's branch-write requester (input FIFO drain) and branch-read requester (output FIFO fill). It gates all traffic on calibration, arbitrates round-robin with bounded bursts, and issues cmd/data in lockstep. It also tracks outstanding reads and flags unsolicited read returns. It runs in the MIG ui_clk domain.

Parameters:
ADDR_W, 27, app_addr width
DATA_W, 128, app data width (one BL8 beat per command)
MAX_BURST, 8, max consecutive commands granted to one requester before re-arbitration
MAX_OUTSTANDING, 16, max issued-but-unreturned reads

Ports:
clk  in  1  ui_clk; all logic on rising edge
sys_rst_n  in  1  asynchronous, active-low reset
init_calib_complete  in  1  MIG calibration done
wr_req  in  1  write requester has a word
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_gnt  out  1  write accepted this cycle
rd_req  in  1  read requester has an address
rd_addr  in  ADDR_W  read address
rd_gnt  out  1  read command accepted this cycle
rd_valid  out  1  = app_rd_data_valid
rd_data  out  DATA_W  = app_rd_data
app_addr  out  ADDR_W  MIG address
app_cmd  out  3  000 write, 001 read
app_en  out  1  MIG command enable
app_wdf_data  out  DATA_W  MIG write data
app_wdf_wren  out  1  MIG write-data enable
app_wdf_end  out  1  = app_wdf_wren
app_wdf_mask  out  DATA_W/8  constant 0
app_sr_req, app_ref_req, app_zq_req  out  1 each  constant 0
app_rdy  in  1  MIG command ready
app_wdf_rdy  in  1  MIG write FIFO ready
app_rd_data  in  DATA_W  MIG read data
app_rd_data_valid  in  1  MIG read data valid
outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
rd_err  out  1  sticky: read data arrived with outstanding==0

Behaviour:
- Reset (async, sys_rst_n=0): state=CALIB, burst_cnt=0, outstanding=0, last_served=READ, rd_err=0. All enables/grants are 0 while in reset.
- States: CALIB, IDLE, WRITE, READ.
- CALIB -> IDLE when init_calib_complete=1. From any state, init_calib_complete=0 -> CALIB next cycle; no command is issued that cycle. outstanding is retained and returns are still counted.
- IDLE: if both req are high, go to the requester not last_served. If one is high, go to it. If none, stay. IDLE issues no commands (1-cycle bubble).
- Entering WRITE/READ: burst_cnt=0, last_served updated.
- WRITE: wr_fire = wr_req & app_rdy & app_wdf_rdy.
  - On wr_fire: app_en=app_wdf_wren=app_wdf_end=1, app_cmd=000, app_addr=wr_addr, app_wdf_data=wr_data, wr_gnt=1, same cycle (combinational from state and inputs).
  - Never assert app_en without app_wdf_wren in WRITE.
- READ: rd_fire = rd_req & app_rdy & (outstanding<MAX_OUTSTANDING).
  - On rd_fire: app_en=1, app_cmd=001, app_addr=rd_addr, rd_gnt=1.
- burst_cnt increments on each fire.
- Leave WRITE/READ for IDLE when any of:
  - req drops;
  - the fire makes burst_cnt reach MAX_BURST;
  - in READ: outstanding==MAX_OUTSTANDING and wr_req=1.
- A stalled MIG (app_rdy=0) holds the state; no timeout.
- outstanding: +1 on rd_fire, −1 on app_rd_data_valid, unchanged when both occur. Never decrements below 0; rd_err is set instead.
- rd_valid/rd_data are pure pass-through (0 latency). Return order is MIG order.
- When idle: app_cmd holds 001, app_addr/app_wdf_data are don't-care, and enables are 0.

Test Plan:
- Hold reset, then release with init_calib_complete=0 for 50 cycles and wr_req=1 -> app_en=0 throughout; first wr_gnt 2 cycles after calib rises (CALIB→IDLE→WRITE).
- wr_req and rd_req both held, app_rdy=app_wdf_rdy=1, MAX_BURST=8 -> 8 writes, 1 bubble, 8 reads, 1 bubble, repeating; write goes first after reset.
- Reads only, app_rd_data_valid never asserted -> exactly 16 rd_gnt, then stall with outstanding=16; one return -> one further grant.
- Writes with app_wdf_rdy toggling every other cycle and app_rdy=1 -> app_en and app_wdf_wren always coincide; grants = number of cycles with both ready high; addresses/data match the input sequence.
- rd_fire and app_rd_data_valid in the same cycle at outstanding=5 -> outstanding stays 5; a return at outstanding=0 -> rd_err=1, held until reset.
- Drop init_calib_complete mid-write-burst -> no app_en next cycle, state=CALIB; outstanding is preserved and resumes counting after recalibration.

Source files
------------

// File: rtl/deint_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// deint_ddr_arbiter
//
// Shares one DDR3 MIG user (app_*) interface between the deinterleaver's
// branch-write requester (input FIFO drain) and branch-read requester
// (output FIFO fill). Runs entirely in the MIG ui_clk domain.
//
// Behaviour summary:
//   - No traffic until init_calib_complete; losing calibration at any time
//     forces the CALIB state and suppresses the command of that cycle.
//   - Round-robin arbitration between the two requesters, each tenure being
//     limited to MAX_BURST commands. Every tenure change passes through a
//     one-cycle IDLE bubble in which no command is issued.
//   - Write command and write data are issued in lockstep (app_en together
//     with app_wdf_wren/app_wdf_end), so the MIG write FIFO never gets ahead
//     of or behind the command queue.
//   - Reads in flight are counted; the read requester is throttled at
//     MAX_OUTSTANDING. A read return with nothing in flight sets a sticky
//     error flag.
//
// Ports:
//   clk, sys_rst_n            ui_clk and asynchronous active-low reset
//   init_calib_complete       MIG calibration done
//   wr_req/wr_addr/wr_data    write requester word, wr_gnt = accepted now
//   rd_req/rd_addr            read requester address, rd_gnt = accepted now
//   rd_valid/rd_data          read return, straight from the MIG
//   app_*                     MIG user interface
//   outstanding               number of reads issued but not yet returned
//   rd_err                    sticky: unsolicited read return seen
// ---------------------------------------------------------------------------
module deint_ddr_arbiter #(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 128,
  parameter int MAX_BURST       = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                 clk,
  input  logic                                 sys_rst_n,
  input  logic                                 init_calib_complete,
  // write requester
  input  logic                                 wr_req,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [DATA_W-1:0]                    wr_data,
  output logic                                 wr_gnt,
  // read requester
  input  logic                                 rd_req,
  input  logic [ADDR_W-1:0]                    rd_addr,
  output logic                                 rd_gnt,
  output logic                                 rd_valid,
  output logic [DATA_W-1:0]                    rd_data,
  // MIG user interface
  output logic [ADDR_W-1:0]                    app_addr,
  output logic [2:0]                           app_cmd,
  output logic                                 app_en,
  output logic [DATA_W-1:0]                    app_wdf_data,
  output logic                                 app_wdf_wren,
  output logic                                 app_wdf_end,
  output logic [DATA_W/8-1:0]                  app_wdf_mask,
  output logic                                 app_sr_req,
  output logic                                 app_ref_req,
  output logic                                 app_zq_req,
  input  logic                                 app_rdy,
  input  logic                                 app_wdf_rdy,
  input  logic [DATA_W-1:0]                    app_rd_data,
  input  logic                                 app_rd_data_valid,
  // status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 rd_err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  // FSM encoding
  localparam logic [1:0] ST_CALIB = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  // Which requester held the interface last (round-robin pointer)
  localparam logic SERVED_WR = 1'b0;
  localparam logic SERVED_RD = 1'b1;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // burst_cnt value at which one more fire completes the tenure
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [BC_W-1:0]  BURST_ZERO = {BC_W{1'b0}};
  localparam logic [BC_W-1:0]  BURST_ONE  = BC_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ZERO   = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] OUT_ONE    = OUT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [BC_W-1:0]  r_burst_cnt;
  logic [BC_W-1:0]  w_burst_nxt;
  logic             r_last_served;
  logic             w_last_nxt;
  logic [OUT_W-1:0] r_outstanding;
  logic [OUT_W-1:0] w_out_nxt;
  logic             r_rd_err;
  logic             w_rd_err_nxt;

  logic             w_out_room;
  logic             w_out_full;
  logic             w_wr_fire;
  logic             w_rd_fire;

  // Fire qualification. Calibration is part of the qualifier so that the
  // cycle in which calibration drops never issues a command, even though
  // the state register still shows WRITE/READ during that cycle.
  always_comb begin
    w_out_room = (r_outstanding < OUT_MAX);
    w_out_full = (r_outstanding == OUT_MAX);
    w_wr_fire  = (r_state == ST_WRITE) && init_calib_complete &&
                 wr_req && app_rdy && app_wdf_rdy;
    w_rd_fire  = (r_state == ST_READ) && init_calib_complete &&
                 rd_req && app_rdy && w_out_room;
  end

  // MIG command/data drive. Write command and write data share a single
  // fire term, so app_en is never raised in WRITE without app_wdf_wren.
  always_comb begin
    app_en       = w_wr_fire || w_rd_fire;
    app_wdf_wren = w_wr_fire;
    app_wdf_end  = w_wr_fire;
    app_wdf_data = wr_data;
    if (w_wr_fire) begin
      app_cmd = CMD_WRITE;
    end else begin
      // READ encoding is the resting value whenever no write is issued
      app_cmd = CMD_READ;
    end
    if (r_state == ST_WRITE) begin
      app_addr = wr_addr;
    end else begin
      app_addr = rd_addr;
    end
  end

  // Constant MIG controls: no masking, no self-refresh/refresh/ZQ requests
  assign app_wdf_mask = {(DATA_W/8){1'b0}};
  assign app_sr_req   = 1'b0;
  assign app_ref_req  = 1'b0;
  assign app_zq_req   = 1'b0;

  // Requester-side handshakes and zero-latency read return
  assign wr_gnt      = w_wr_fire;
  assign rd_gnt      = w_rd_fire;
  assign rd_valid    = app_rd_data_valid;
  assign rd_data     = app_rd_data;
  assign outstanding = r_outstanding;
  assign rd_err      = r_rd_err;

  // Arbitration FSM next-state, burst counter and round-robin pointer
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_last_nxt  = r_last_served;
    if (!init_calib_complete) begin
      w_state_nxt = ST_CALIB;
    end else begin
      case (r_state)
        ST_CALIB: begin
          w_state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          // Both pending: serve the one that did not go last
          if (wr_req && rd_req) begin
            w_burst_nxt = BURST_ZERO;
            if (r_last_served == SERVED_RD) begin
              w_state_nxt = ST_WRITE;
              w_last_nxt  = SERVED_WR;
            end else begin
              w_state_nxt = ST_READ;
              w_last_nxt  = SERVED_RD;
            end
          end else if (wr_req) begin
            w_state_nxt = ST_WRITE;
            w_burst_nxt = BURST_ZERO;
            w_last_nxt  = SERVED_WR;
          end else if (rd_req) begin
            w_state_nxt = ST_READ;
            w_burst_nxt = BURST_ZERO;
            w_last_nxt  = SERVED_RD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (w_wr_fire) begin
            w_burst_nxt = r_burst_cnt + BURST_ONE;
          end else begin
            w_burst_nxt = r_burst_cnt;
          end
          // A stalled MIG simply holds here with the request still up
          if (!wr_req || (w_wr_fire && (r_burst_cnt == BURST_LAST))) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end
        ST_READ: begin
          if (w_rd_fire) begin
            w_burst_nxt = r_burst_cnt + BURST_ONE;
          end else begin
            w_burst_nxt = r_burst_cnt;
          end
          // Give way to writes when reads are throttled by the in-flight cap;
          // with no writer waiting, keep the tenure and wait for returns.
          if (!rd_req || (w_rd_fire && (r_burst_cnt == BURST_LAST)) ||
              (w_out_full && wr_req)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_READ;
          end
        end
        default: begin
          w_state_nxt = ST_CALIB;
        end
      endcase
    end
  end

  // In-flight read accounting and unsolicited-return detection. Returns are
  // counted in every state, including CALIB, so the count survives a
  // recalibration.
  always_comb begin
    w_out_nxt = r_outstanding;
    if (app_rd_data_valid && (r_outstanding == OUT_ZERO)) begin
      w_rd_err_nxt = 1'b1;
    end else begin
      w_rd_err_nxt = r_rd_err;
    end
    case ({w_rd_fire, app_rd_data_valid})
      2'b10: begin
        // fire only happens below OUT_MAX, so no overflow
        w_out_nxt = r_outstanding + OUT_ONE;
      end
      2'b01: begin
        if (r_outstanding != OUT_ZERO) begin
          w_out_nxt = r_outstanding - OUT_ONE;
        end else begin
          w_out_nxt = r_outstanding;
        end
      end
      default: begin
        // idle, or an issue and a return cancelling each other
        w_out_nxt = r_outstanding;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_CALIB;
      r_burst_cnt   <= BURST_ZERO;
      r_last_served <= SERVED_RD;
      r_outstanding <= OUT_ZERO;
      r_rd_err      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_burst_cnt   <= w_burst_nxt;
      r_last_served <= w_last_nxt;
      r_outstanding <= w_out_nxt;
      r_rd_err      <= w_rd_err_nxt;
    end
  end

endmodule

// File: tb/tb_deint_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_deint_ddr_arbiter
//
// Self-checking bench for deint_ddr_arbiter. Requester and MIG models are
// driven on the falling edge; DUT outputs are sampled 2 ns later. Expected
// write words, read addresses and read-return data are queued when the
// stimulus presents them and popped when the DUT issues/returns them.
// ---------------------------------------------------------------------------
module tb_deint_ddr_arbiter;

  localparam int AW = 27;
  localparam int DW = 128;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          sys_rst_n;
  logic          init_calib_complete;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic          app_sr_req;
  logic          app_ref_req;
  logic          app_zq_req;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic [OW-1:0] outstanding;
  logic          rd_err;

  always #5 clk = ~clk;

  deint_ddr_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(8), .MAX_OUTSTANDING(16)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .outstanding(outstanding), .rd_err(rd_err)
  );

  int errors = 0;
  int checks = 0;

  // scoreboards
  logic [AW+DW-1:0] wq[$];
  logic [AW-1:0]    rq[$];
  logic [AW-1:0]    mig_q[$];
  logic [DW-1:0]    dq[$];

  // requester / MIG model state
  bit   wr_on, rd_on, wr_pres, rd_pres, wr_taken, rd_taken, auto_ret, ret_now;
  int   ret_n;
  int   wr_seq = 0;
  int   rd_seq = 0;
  int   n_wr, n_rd, n_en;
  int   code;  // 0 none, 1 write grant, 2 read grant in the last cycle
  logic [DW-1:0] ret_data;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ret_word(input logic [AW-1:0] a);
    return {4{5'd0, a}};
  endfunction

  // One clock cycle: called at a falling edge, returns at the next one
  task automatic cycle();
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    if (wr_taken) begin wr_taken = 1'b0; wr_pres = 1'b0; end
    if (wr_on && !wr_pres) begin
      wr_seq++;
      wr_addr = 27'h100 + AW'(wr_seq);
      wr_data = {4{32'hA500_0000 + 32'(wr_seq)}};
      wq.push_back({wr_addr, wr_data});
      wr_pres = 1'b1;
    end else if (!wr_on && wr_pres) begin
      void'(wq.pop_back());
      wr_pres = 1'b0;
    end
    wr_req = wr_pres;
    if (rd_taken) begin rd_taken = 1'b0; rd_pres = 1'b0; end
    if (rd_on && !rd_pres) begin
      rd_seq++;
      rd_addr = 27'h4000 + AW'(rd_seq);
      rq.push_back(rd_addr);
      rd_pres = 1'b1;
    end else if (!rd_on && rd_pres) begin
      void'(rq.pop_back());
      rd_pres = 1'b0;
    end
    rd_req = rd_pres;
    ret_now = 1'b0;
    if (auto_ret && mig_q.size() > 0) begin
      ret_data = ret_word(mig_q.pop_front());
      ret_now = 1'b1;
    end else if (ret_n > 0) begin
      ret_n--;
      if (mig_q.size() > 0) ret_data = ret_word(mig_q.pop_front());
      else ret_data = ret_word(27'h7ABCDE);
      ret_now = 1'b1;
    end
    app_rd_data_valid = ret_now;
    app_rd_data = ret_now ? ret_data : '0;
    if (ret_now) dq.push_back(ret_data);
    #2;
    code = 0;
    if (app_en) n_en++;
    check_eq("en_vs_gnt", 128'(app_en), 128'(wr_gnt | rd_gnt));
    check_eq("wren_vs_wgnt", 128'({app_wdf_wren, app_wdf_end}), 128'({wr_gnt, wr_gnt}));
    if (wr_gnt) begin
      code = 1; n_wr++; wr_taken = 1'b1;
      check_eq("w_cmd", 128'(app_cmd), 128'(3'b000));
      check_eq("w_ready", 128'({app_rdy, app_wdf_rdy}), 128'(2'b11));
      check_eq("w_sb_nonempty", 128'(wq.size() != 0), 128'(1));
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check_eq("w_addr", 128'(app_addr), 128'(e[AW+DW-1:DW]));
        check_eq("w_data", app_wdf_data, e[DW-1:0]);
      end
    end
    if (rd_gnt) begin
      code = 2; n_rd++; rd_taken = 1'b1;
      check_eq("r_cmd", 128'(app_cmd), 128'(3'b001));
      check_eq("r_sb_nonempty", 128'(rq.size() != 0), 128'(1));
      if (rq.size() != 0) begin
        a = rq.pop_front();
        check_eq("r_addr", 128'(app_addr), 128'(a));
      end
      mig_q.push_back(app_addr);
    end
    if (ret_now) begin
      d = dq.pop_front();
      check_eq("ret_valid", 128'(rd_valid), 128'(1));
      check_eq("ret_data", rd_data, d);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst_n = 1'b0;
    wr_on = 0; rd_on = 0; wr_pres = 0; rd_pres = 0; wr_taken = 0; rd_taken = 0;
    auto_ret = 0; ret_n = 0; n_wr = 0; n_rd = 0; n_en = 0;
    wq.delete(); rq.delete(); mig_q.delete(); dq.delete();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    #2;
    check_eq("rst_en", 128'({app_en, wr_gnt, rd_gnt, app_wdf_wren}), 128'(4'b0000));
    check_eq("rst_out", 128'(outstanding), 128'(0));
    check_eq("rst_err", 128'(rd_err), 128'(0));
    check_eq("rst_cmd", 128'(app_cmd), 128'(3'b001));
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, base, m_pre, m_b, exp_code, k;
    bit m_wr;
    sys_rst_n = 1'b0; init_calib_complete = 1'b0;
    wr_req = 0; rd_req = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    app_rdy = 1; app_wdf_rdy = 1; app_rd_data = '0; app_rd_data_valid = 0;

    // 1: calibration gating and CALIB -> IDLE -> WRITE latency
    init_calib_complete = 1'b0;
    do_reset();
    wr_on = 1;
    repeat (50) cycle();
    check_eq("calib_no_en", 128'(n_en), 128'(0));
    init_calib_complete = 1'b1;
    cycle(); check_eq("calib_c0", 128'(code), 128'(0));
    cycle(); check_eq("calib_c1", 128'(code), 128'(0));
    cycle(); check_eq("calib_first_wgnt", 128'(code), 128'(1));
    check_eq("const_ctrl", 128'({app_wdf_mask, app_sr_req, app_ref_req, app_zq_req}), 128'(0));
    wr_on = 0;
    repeat (3) cycle();

    // 2: both requesters, round-robin 8/bubble/8/bubble, write first
    do_reset();
    wr_on = 1; rd_on = 1; auto_ret = 1;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (c < 2) exp_code = 0;
      else begin
        k = (c - 2) % 18;
        if (k < 8) exp_code = 1;
        else if (k == 8 || k == 17) exp_code = 0;
        else exp_code = 2;
      end
      check_eq("rr_pattern", 128'(code), 128'(exp_code));
    end
    wr_on = 0; rd_on = 0;
    repeat (4) cycle();
    check_eq("rr_no_err", 128'(rd_err), 128'(0));

    // 3: reads only, no returns -> capped at 16, one return -> one more
    do_reset();
    rd_on = 1;
    repeat (60) cycle();
    check_eq("cap_grants", 128'(n_rd), 128'(16));
    check_eq("cap_out", 128'(outstanding), 128'(16));
    ret_n = 1;
    repeat (10) cycle();
    check_eq("cap_grants_after_ret", 128'(n_rd), 128'(17));
    check_eq("cap_out_after_ret", 128'(outstanding), 128'(16));
    rd_on = 0;
    cycle();

    // 4: writes with app_wdf_rdy toggling
    do_reset();
    wr_on = 1; m_pre = 2; m_wr = 0; m_b = 0;
    for (int c = 0; c < 60; c++) begin
      app_wdf_rdy = (c % 2 == 1);
      cycle();
      exp_code = 0;
      if (m_pre > 0) begin
        m_pre--; if (m_pre == 0) m_wr = 1; m_b = 0;
      end else if (m_wr) begin
        if (app_wdf_rdy) begin
          exp_code = 1; m_b++;
          if (m_b == 8) m_wr = 0;
        end
      end else begin
        m_wr = 1; m_b = 0;
      end
      check_eq("tog_wgnt", 128'(code), 128'(exp_code));
    end
    app_wdf_rdy = 1; wr_on = 0;
    repeat (3) cycle();

    // 5a: issue and return in the same cycle at outstanding=5
    do_reset();
    rd_on = 1; g = 0;
    while (outstanding != 5 && g < 40) begin cycle(); g++; end
    check_eq("reach_out5", 128'(outstanding), 128'(5));
    ret_n = 1;
    cycle();
    check_eq("same_cyc_gnt", 128'(code), 128'(2));
    rd_on = 0;
    check_eq("same_cyc_out", 128'(outstanding), 128'(5));
    cycle();

    // 5b: unsolicited return sets sticky rd_err
    do_reset();
    check_eq("err_clear", 128'(rd_err), 128'(0));
    ret_n = 1;
    cycle();
    check_eq("err_set", 128'(rd_err), 128'(1));
    repeat (5) cycle();
    check_eq("err_held", 128'(rd_err), 128'(1));
    check_eq("err_out_zero", 128'(outstanding), 128'(0));

    // 6: calibration lost mid-write-burst
    do_reset();
    rd_on = 1; g = 0;
    while (outstanding != 3 && g < 40) begin cycle(); g++; end
    rd_on = 0;
    cycle();
    wr_on = 1; g = 0;
    while (n_wr < 3 && g < 40) begin cycle(); g++; end
    check_eq("recal_in_burst", 128'(n_wr), 128'(3));
    init_calib_complete = 1'b0;
    cycle(); check_eq("recal_drop_c0", 128'(code), 128'(0));
    cycle(); check_eq("recal_drop_c1", 128'(code), 128'(0));
    check_eq("recal_out_kept", 128'(outstanding), 128'(3));
    ret_n = 1;
    cycle();
    check_eq("recal_ret_counted", 128'(outstanding), 128'(2));
    init_calib_complete = 1'b1;
    wr_on = 0; rd_on = 1;
    base = n_rd; g = 0;
    while (n_rd == base && g < 10) begin cycle(); g++; end
    check_eq("recal_resume", 128'(outstanding), 128'(3));
    rd_on = 0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
